// File: rtl/shader_pkg.sv
// Shared definitions for the programmable pixel shader: opcodes, instruction
// field positions and the sequencer state encoding.
package shader_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_MOV  = 4'h2;
    localparam logic [3:0] OP_ADDI = 4'h3;
    localparam logic [3:0] OP_SUBI = 4'h4;
    localparam logic [3:0] OP_ADD  = 4'h5;
    localparam logic [3:0] OP_SHR  = 4'h6;
    localparam logic [3:0] OP_MULI = 4'h7;
    localparam logic [3:0] OP_END  = 4'hF;

    // rs shares the low bits of the immediate field
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 10;
    localparam int RD_LSB  = 8;
    localparam int RS_MSB  = 2;
    localparam int RS_LSB  = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // Only LDI..MULI produce a register result; END and 8..E leave registers alone
    function automatic logic writesRd(input logic [3:0] op);
        return (op >= OP_LDI) && (op <= OP_MULI);
    endfunction

endpackage

// File: rtl/shader_alu.sv
// Combinational shader datapath. Every result is formed at PIX_W+8 bits so
// that sums and scaled products can be clamped to full scale instead of wrapping.
module shader_alu
    import shader_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic [3:0]       op_i,
    input  logic [PIX_W-1:0] a_i,
    input  logic [PIX_W-1:0] b_i,
    input  logic [7:0]       imm_i,
    output logic [PIX_W-1:0] result_o
);

    localparam int WIDE_W = PIX_W + 8;

    logic [WIDE_W-1:0] aWide;
    logic [WIDE_W-1:0] bWide;
    logic [WIDE_W-1:0] immWide;
    logic [WIDE_W-1:0] wideResult;
    logic [WIDE_W-1:0] maxVal;

    assign aWide   = {8'b0, a_i};
    assign bWide   = {8'b0, b_i};
    assign immWide = {{PIX_W{1'b0}}, imm_i};
    assign maxVal  = {8'b0, {PIX_W{1'b1}}};

    // Wide result per opcode; MULI treats imm=128 as unity gain, unknown ops pass rd through
    always_comb begin
        wideResult = aWide;
        case (op_i)
            OP_LDI:  wideResult = immWide;
            OP_MOV:  wideResult = bWide;
            OP_ADDI: wideResult = aWide + immWide;
            OP_SUBI: wideResult = (aWide >= immWide) ? (aWide - immWide) : '0;
            OP_ADD:  wideResult = aWide + bWide;
            OP_SHR:  wideResult = aWide >> imm_i[3:0];
            OP_MULI: wideResult = (aWide * immWide) >> 7;
            default: wideResult = aWide;
        endcase
    end

    // Clamp to the largest representable pixel value
    always_comb begin
        result_o = wideResult[PIX_W-1:0];
        if (wideResult > maxVal) begin
            result_o = {PIX_W{1'b1}};
        end
    end

endmodule

// File: rtl/shader_pipe_core.sv
// Programmable per-pixel shader core: captures a pixel into R0 on start, runs
// the stored program one instruction per cycle and pulses done with the result.
module shader_pipe_core
    import shader_pkg::*;
#(
    parameter int PIX_W      = 8,
    parameter int NREG       = 8,
    parameter int PROG_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [PIX_W-1:0]              pixel_in,
    input  logic                          prog_we,
    input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
    input  logic [15:0]                   prog_data,
    output logic [PIX_W-1:0]              pixel_out,
    output logic                          done,
    output logic                          busy
);

    localparam int AW  = $clog2(PROG_DEPTH);
    localparam int RIW = $clog2(NREG);

    logic [15:0]      progMem [PROG_DEPTH];
    state_t           state_q;
    logic [AW-1:0]    pc_q;
    logic [PIX_W-1:0] regs_q [NREG];
    logic [PIX_W-1:0] pixelOut_q;
    logic             done_q;
    logic             busy_q;

    logic [3:0]       op;
    logic [2:0]       rdIdx;
    logic [2:0]       rsIdx;
    logic [7:0]       imm;
    logic [PIX_W-1:0] rdVal;
    logic [PIX_W-1:0] rsVal;
    logic [PIX_W-1:0] aluResult;
    logic             rdWrite;
    logic [PIX_W-1:0] r1_d;
    logic             lastAddr;

    assign op    = progMem[pc_q][OP_MSB:OP_LSB];
    assign rdIdx = progMem[pc_q][RD_MSB:RD_LSB];
    assign rsIdx = progMem[pc_q][RS_MSB:RS_LSB];
    assign imm   = progMem[pc_q][IMM_MSB:IMM_LSB];

    assign lastAddr = (pc_q == AW'(PROG_DEPTH - 1));

    // Register reads; indices beyond the implemented file read as zero
    always_comb begin
        rdVal = '0;
        rsVal = '0;
        if (int'(rdIdx) < NREG) begin
            rdVal = regs_q[rdIdx[RIW-1:0]];
        end
        if (int'(rsIdx) < NREG) begin
            rsVal = regs_q[rsIdx[RIW-1:0]];
        end
    end

    // Write qualification and the R1 value seen after this instruction, used by the implicit end
    always_comb begin
        rdWrite = writesRd(op) && (int'(rdIdx) < NREG);
        r1_d    = regs_q[1];
        if (rdWrite && (rdIdx == 3'd1)) begin
            r1_d = aluResult;
        end
    end

    shader_alu #(
        .PIX_W (PIX_W)
    ) u_alu (
        .op_i     (op),
        .a_i      (rdVal),
        .b_i      (rsVal),
        .imm_i    (imm),
        .result_o (aluResult)
    );

    // Instruction store: writes only land while idle so a running program is never altered
    always_ff @(posedge clk) begin
        if (prog_we && (state_q == IDLE)) begin
            progMem[prog_addr] <= prog_data;
        end
    end

    // Sequencer, register file and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            pixelOut_q <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        regs_q[0] <= pixel_in;
                        pc_q      <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    if (op == OP_END) begin
                        pixelOut_q <= rdVal;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        pc_q       <= '0;
                        state_q    <= IDLE;
                    end else begin
                        if (rdWrite) begin
                            regs_q[rdIdx[RIW-1:0]] <= aluResult;
                        end
                        pc_q <= pc_q + AW'(1);
                        if (lastAddr) begin
                            pixelOut_q <= r1_d;
                            done_q     <= 1'b1;
                            busy_q     <= 1'b0;
                            pc_q       <= '0;
                            state_q    <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pixel_out = pixelOut_q;
    assign done      = done_q;
    assign busy      = busy_q;

endmodule

// File: doc/shader_pipe_core.md
# shader_pipe_core

Programmable per-pixel shader core: accepts one pixel on a `start` handshake, runs a short program from a writable instruction store (one instruction per cycle), and returns the shaded pixel with a one-cycle `done` pulse. It is the parametrised successor of the fixed brightness shader unit in the pixel path. Pixel width, register count and program depth are generalised, and it adds saturating arithmetic, scaling and a runtime-loadable program. It sits between the pixel fetch stage and the VGA output stage.

## Interface
Parameters:
- `PIX_W`, 8: pixel and register width, 8..16.
- `NREG`, 8: general registers R0..R(NREG-1), 2..8.
- `PROG_DEPTH`, 16: instruction store depth, power of two, 4..64.

Ports:
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request to shade `pixel_in`; sampled only in IDLE.
- `pixel_in`  in  PIX_W: input pixel, captured into R0 on accepted `start`.
- `prog_we`  in  1: instruction store write enable.
- `prog_addr`  in  $clog2(PROG_DEPTH): write address.
- `prog_data`  in  16: instruction word.
- `pixel_out`  out  PIX_W: result, valid while `done`=1; holds until the next result.
- `done`  out  1: one-cycle result pulse.
- `busy`  out  1: high from accepted `start` until the END edge.

## Operation
- Instruction format: op[15:12], rd[10:8], rs[2:0], imm[7:0]. imm is zero-extended to PIX_W, or truncated to PIX_W if PIX_W<8 (not reachable with the allowed range).
- Opcodes:
  - 0 NOP.
  - 1 LDI: rd=imm.
  - 2 MOV: rd=rs.
  - 3 ADDI: rd=sat(rd+imm).
  - 4 SUBI: rd=max(rd-imm,0).
  - 5 ADD: rd=sat(rd+rs).
  - 6 SHR: rd=rd>>imm[3:0].
  - 7 MULI: rd=sat((rd*imm)>>7), where imm 128 = unity gain.
  - F END: pixel_out=R[rd], done=1.
  - Opcodes 8..E execute as NOP.
- Saturation: results are computed at PIX_W+8 bits, then clamped to 2^PIX_W-1.
- Register indices ≥NREG: writes are dropped, reads return 0.
- FSM:
  - IDLE: `start`=1 → R0←pixel_in, pc←0, go to RUN.
  - RUN: execute prog[pc], pc←pc+1. END → IDLE.
  - Implicit end: executing address PROG_DEPTH-1 when it is not END still executes that instruction, then outputs R1, pulses done and goes to IDLE.
- R1..R(NREG-1) persist across pixels. Only R0 is reloaded on each start.
- `prog_we` is honoured in IDLE only and ignored while busy, so the running program is never modified.
- `start` while busy is ignored; it is not queued.

## Timing
- Accepted `start` at edge 0. Instruction at address i executes at edge i+1.
- END at address n: pixel_out/done are registered at edge n+1, so `done` is high during cycle n+1. Latency is n+1 cycles.
- `busy` falls at the END edge. A `start` sampled while `done`=1 is accepted, giving back-to-back pixels.
- A write to the instruction store in IDLE is visible to a `start` accepted on the next edge or later. A same-edge write and start both take effect; the write lands before pc=0 is fetched.
- Reset values:
  - pixel_out=0, done=0, busy=0.
  - State IDLE, pc=0.
  - All registers 0.
  - Instruction store is not cleared.
- Reset mid-RUN aborts with no done pulse. The next cycle is IDLE.

## Structure
- Shared package `shader_pkg`:
  - opcode localparams.
  - FSM state enum {IDLE, RUN}.
  - Instruction field positions.
- Sub-module `shader_alu`: combinational; inputs op, a, b, imm; output the saturated PIX_W result. It is parametrised by PIX_W.
- Top level: instruction store (registered write, combinational read), register file, pc and FSM.

## Test plan
- Program {MOV R1,R0; ADDI R1,20; END R1}, pixel 100 → pixel_out=120, done high exactly 3 cycles after start, busy low the same edge.
- Same program, pixel 250 → 255 (saturates). Program {MOV R1,R0; SUBI R1,20; END R1}, pixel 5 → 0.
- MULI 64 on pixel 200 → 100. MULI 255 on 200 → 255. SHR 2 on 200 → 50. With PIX_W=10, ADDI 20 on 1010 → 1023.
- Back-to-back: start held high across done → second pixel accepted on the done cycle, result after the same latency. Start pulses while busy are ignored, yielding exactly one done per accepted start.
- Reset asserted at cycle 2 of a 6-instruction program → no done, outputs 0, IDLE next cycle. A following start runs normally.
- No END in the program (all NOPs, PROG_DEPTH=16) → done at cycle 16 with R1. prog_we during RUN leaves the stored word unchanged (read back by executing it afterwards).
